cluster_pwr_seq: RTL and testbench
==================================

CLUSTER_PWR_SEQ -- requirements
Module: cluster_pwr_seq

Interface
REQ-001 SHALL have parameter BOOT_ADDR_W, default 64, width of the cluster boot address.
REQ-002 SHALL have parameter DLY_W, default 8, width of the settle and hold counters.
REQ-003 SHALL have parameter TIMEOUT_W, default 16, width of the drain timeout counter (used only with CLUSTER_SEQ_TIMEOUT_EN).
REQ-004 SHALL have ports:
- clk_i  in  1  single clock; all state changes on its rising edge.
- rst_ni  in  1  synchronous, active-low reset.
- pwr_req_i  in  1  level; 1 = cluster on requested, 0 = off requested.
- boot_addr_i  in  BOOT_ADDR_W  boot address, sampled on entry to BOOT.
- settle_cycles_i  in  DLY_W  power-settle wait, in cycles.
- rst_hold_cycles_i  in  DLY_W  clock-on reset-hold wait, in cycles.
- cluster_busy_i  in  1  cluster activity flag.
- cluster_pow_o  out  1  cluster power enable.
- cluster_clk_en_o  out  1  cluster clock gate enable.
- cluster_rstn_o  out  1  cluster reset, active low.
- cluster_fetch_enable_o  out  1  cluster core fetch enable.
- cluster_boot_addr_o  out  BOOT_ADDR_W  registered boot address.
- seq_state_o  out  3  current FSM state encoding.
- seq_done_o  out  1  one-cycle pulse on entry to RUN or OFF.
- timeout_err_o  out  1  sticky drain-timeout flag (tied 0 without the macro).

Function
REQ-005 SHALL implement states OFF=0, PWR_UP=1, CLK_ON=2, BOOT=3, RUN=4, DRAIN=5, RST_ON=6, PWR_DN=7; seq_state_o SHALL equal the state register.
REQ-006 OFF: all control outputs 0; pwr_req_i=1 -> PWR_UP, loading the counter with settle_cycles_i.
REQ-007 PWR_UP: cluster_pow_o=1; the counter decrements each cycle; at counter==0 -> CLK_ON, loading rst_hold_cycles_i; a loaded value of 0 SHALL give exactly one cycle in the state.
REQ-008 CLK_ON: cluster_pow_o=1 and cluster_clk_en_o=1, with cluster_rstn_o still 0; same counting rule -> BOOT.
REQ-009 BOOT (one cycle): latch boot_addr_i into cluster_boot_addr_o; drive cluster_rstn_o=1; -> RUN.
REQ-010 RUN: pow, clk_en, rstn and fetch_enable all 1; fetch_enable SHALL first be 1 in the cycle after rstn first goes to 1; pwr_req_i=0 -> DRAIN.
REQ-011 DRAIN: fetch_enable=0, others held; cluster_busy_i=0 sampled -> RST_ON; pwr_req_i=1 while still busy -> RUN, with no reset of the cluster.
REQ-012 RST_ON (one cycle): rstn=0, clk_en still 1; -> PWR_DN.
REQ-013 PWR_DN (one cycle): clk_en=0, pow=1, rstn=0; -> OFF.
REQ-014 A power-on request SHALL be honoured only from OFF; pwr_req_i toggles during PWR_UP/CLK_ON/BOOT SHALL be ignored until RUN is reached.
REQ-015 seq_done_o SHALL pulse in the first cycle of RUN and the first cycle of OFF (except the OFF entered by reset).
REQ-016 cluster_boot_addr_o SHALL hold its value until the next BOOT.
REQ-017 All outputs SHALL be registered (no combinational input-to-output paths).

Reset
REQ-018 rst_ni=0 at a clock edge SHALL force OFF, counters 0, boot address 0, timeout_err_o=0 and all outputs 0, from any state including mid-sequence.
REQ-019 After reset release, no output SHALL change until pwr_req_i=1 is sampled.

Configuration
REQ-020 Macro CLUSTER_SEQ_TIMEOUT_EN defined: DRAIN SHALL count cycles with busy=1 and pwr_req_i=0; reaching 2^TIMEOUT_W-1 SHALL set timeout_err_o and force RST_ON; timeout_err_o SHALL clear only on reset.
REQ-021 Macro undefined: no timeout counter; DRAIN waits indefinitely; timeout_err_o=0.

Verification
REQ-022 settle=3, hold=2, boot_addr=0x1C008080, then pwr_req 0->1: pow rises at cycle 1, clk_en at cycle 5, rstn at cycle 8, fetch_en at cycle 9, boot_addr_o=0x1C008080, seq_done at cycle 9.
REQ-023 settle=0, hold=0: PWR_UP and CLK_ON last exactly one cycle each.
REQ-024 In RUN, drop pwr_req with busy=1 for 10 cycles, then 0: fetch_en falls next cycle, rstn falls after busy drops, clk_en falls one cycle later, pow falls one cycle after that, seq_done pulses in OFF.
REQ-025 In DRAIN with busy=1, reassert pwr_req: returns to RUN, rstn stays 1 throughout, fetch_en becomes 1 again.
REQ-026 Assert rst_ni=0 during CLK_ON: next cycle state=OFF and all outputs 0.
REQ-027 With CLUSTER_SEQ_TIMEOUT_EN and TIMEOUT_W=4, busy stuck at 1 in DRAIN: timeout_err_o sets after 15 cycles, the FSM reaches OFF, and the flag stays set.

Source files
------------

// File: rtl/cluster_pwr_seq.sv
// Cluster power sequencer: power-up, clock, reset release and boot, then drain and power-down.
// Optional drain timeout is enabled by defining CLUSTER_SEQ_TIMEOUT_EN.
module cluster_pwr_seq #(
    parameter int unsigned BOOT_ADDR_W = 64,
    parameter int unsigned DLY_W       = 8,
    parameter int unsigned TIMEOUT_W   = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   pwr_req_i,
    input  logic [BOOT_ADDR_W-1:0] boot_addr_i,
    input  logic [DLY_W-1:0]       settle_cycles_i,
    input  logic [DLY_W-1:0]       rst_hold_cycles_i,
    input  logic                   cluster_busy_i,
    output logic                   cluster_pow_o,
    output logic                   cluster_clk_en_o,
    output logic                   cluster_rstn_o,
    output logic                   cluster_fetch_enable_o,
    output logic [BOOT_ADDR_W-1:0] cluster_boot_addr_o,
    output logic [2:0]             seq_state_o,
    output logic                   seq_done_o,
    output logic                   timeout_err_o
);

    typedef enum logic [2:0] {
        OFF    = 3'd0,
        PWR_UP = 3'd1,
        CLK_ON = 3'd2,
        BOOT   = 3'd3,
        RUN    = 3'd4,
        DRAIN  = 3'd5,
        RST_ON = 3'd6,
        PWR_DN = 3'd7
    } state_t;

    typedef struct packed {
        logic pow;
        logic clk_en;
        logic rstn;
        logic fetch;
    } ctrl_t;

    state_t                 state_q;
    ctrl_t                  ctrl_q;
    logic [DLY_W-1:0]       cnt_q;
    logic [BOOT_ADDR_W-1:0] boot_addr_q;
    logic                   done_q;
    logic                   tmo_fire;

    // Control outputs are registered from the state being entered, so they
    // always line up with the state register in the same cycle.
    function automatic ctrl_t ctrl_of(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            PWR_UP:  c = '{pow: 1'b1, clk_en: 1'b0, rstn: 1'b0, fetch: 1'b0};
            CLK_ON:  c = '{pow: 1'b1, clk_en: 1'b1, rstn: 1'b0, fetch: 1'b0};
            BOOT:    c = '{pow: 1'b1, clk_en: 1'b1, rstn: 1'b1, fetch: 1'b0};
            RUN:     c = '{pow: 1'b1, clk_en: 1'b1, rstn: 1'b1, fetch: 1'b1};
            DRAIN:   c = '{pow: 1'b1, clk_en: 1'b1, rstn: 1'b1, fetch: 1'b0};
            RST_ON:  c = '{pow: 1'b1, clk_en: 1'b1, rstn: 1'b0, fetch: 1'b0};
            PWR_DN:  c = '{pow: 1'b1, clk_en: 1'b0, rstn: 1'b0, fetch: 1'b0};
            default: c = '0;
        endcase
        return c;
    endfunction

`ifdef CLUSTER_SEQ_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    logic [TIMEOUT_W-1:0] tmo_q;
    logic                 tmo_err_q;

    // Fires on the (2^TIMEOUT_W-1)th stalled drain cycle.
    assign tmo_fire = (state_q == DRAIN) && cluster_busy_i && !pwr_req_i
                      && (tmo_q == TMO_LAST);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tmo_q     <= '0;
            tmo_err_q <= 1'b0;
        end else if (state_q != DRAIN) begin
            tmo_q <= '0;
        end else if (tmo_fire) begin
            tmo_err_q <= 1'b1;
        end else if (cluster_busy_i && !pwr_req_i) begin
            tmo_q <= tmo_q + 1'b1;
        end
    end

    assign timeout_err_o = tmo_err_q;
`else
    assign tmo_fire      = 1'b0;
    assign timeout_err_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= OFF;
            ctrl_q      <= '0;
            cnt_q       <= '0;
            boot_addr_q <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                OFF: begin
                    if (pwr_req_i) begin
                        state_q <= PWR_UP;
                        ctrl_q  <= ctrl_of(PWR_UP);
                        cnt_q   <= settle_cycles_i;
                    end
                end
                PWR_UP: begin
                    if (cnt_q == '0) begin
                        state_q <= CLK_ON;
                        ctrl_q  <= ctrl_of(CLK_ON);
                        cnt_q   <= rst_hold_cycles_i;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                CLK_ON: begin
                    if (cnt_q == '0) begin
                        state_q     <= BOOT;
                        ctrl_q      <= ctrl_of(BOOT);
                        boot_addr_q <= boot_addr_i;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                BOOT: begin
                    state_q <= RUN;
                    ctrl_q  <= ctrl_of(RUN);
                    done_q  <= 1'b1;
                end
                RUN: begin
                    if (!pwr_req_i) begin
                        state_q <= DRAIN;
                        ctrl_q  <= ctrl_of(DRAIN);
                    end
                end
                DRAIN: begin
                    // An idle cluster is shut down even if power is requested again.
                    if (!cluster_busy_i || tmo_fire) begin
                        state_q <= RST_ON;
                        ctrl_q  <= ctrl_of(RST_ON);
                    end else if (pwr_req_i) begin
                        state_q <= RUN;
                        ctrl_q  <= ctrl_of(RUN);
                        done_q  <= 1'b1;
                    end
                end
                RST_ON: begin
                    state_q <= PWR_DN;
                    ctrl_q  <= ctrl_of(PWR_DN);
                end
                PWR_DN: begin
                    state_q <= OFF;
                    ctrl_q  <= ctrl_of(OFF);
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= OFF;
                    ctrl_q  <= '0;
                end
            endcase
        end
    end

    assign cluster_pow_o          = ctrl_q.pow;
    assign cluster_clk_en_o       = ctrl_q.clk_en;
    assign cluster_rstn_o         = ctrl_q.rstn;
    assign cluster_fetch_enable_o = ctrl_q.fetch;
    assign cluster_boot_addr_o    = boot_addr_q;
    assign seq_state_o            = state_q;
    assign seq_done_o             = done_q;

endmodule

// File: tb/tb_cluster_pwr_seq.sv
// Directed bench for cluster_pwr_seq; timeout steps run when CLUSTER_SEQ_TIMEOUT_EN is defined.
module tb_cluster_pwr_seq;

    localparam int unsigned BAW = 64;
    localparam int unsigned DW  = 8;
    localparam int unsigned TW  = 4;

    localparam logic [2:0] S_OFF    = 3'd0;
    localparam logic [2:0] S_PWR_UP = 3'd1;
    localparam logic [2:0] S_CLK_ON = 3'd2;
    localparam logic [2:0] S_BOOT   = 3'd3;
    localparam logic [2:0] S_RUN    = 3'd4;
    localparam logic [2:0] S_DRAIN  = 3'd5;
    localparam logic [2:0] S_RST_ON = 3'd6;
    localparam logic [2:0] S_PWR_DN = 3'd7;

    logic           clk_i = 1'b0;
    logic           rst_ni;
    logic           pwr_req_i;
    logic [BAW-1:0] boot_addr_i;
    logic [DW-1:0]  settle_cycles_i;
    logic [DW-1:0]  rst_hold_cycles_i;
    logic           cluster_busy_i;
    logic           cluster_pow_o;
    logic           cluster_clk_en_o;
    logic           cluster_rstn_o;
    logic           cluster_fetch_enable_o;
    logic [BAW-1:0] cluster_boot_addr_o;
    logic [2:0]     seq_state_o;
    logic           seq_done_o;
    logic           timeout_err_o;

    int total = 0;
    int bad   = 0;

    cluster_pwr_seq #(
        .BOOT_ADDR_W (BAW),
        .DLY_W       (DW),
        .TIMEOUT_W   (TW)
    ) dut (
        .clk_i                  (clk_i),
        .rst_ni                 (rst_ni),
        .pwr_req_i              (pwr_req_i),
        .boot_addr_i            (boot_addr_i),
        .settle_cycles_i        (settle_cycles_i),
        .rst_hold_cycles_i      (rst_hold_cycles_i),
        .cluster_busy_i         (cluster_busy_i),
        .cluster_pow_o          (cluster_pow_o),
        .cluster_clk_en_o       (cluster_clk_en_o),
        .cluster_rstn_o         (cluster_rstn_o),
        .cluster_fetch_enable_o (cluster_fetch_enable_o),
        .cluster_boot_addr_o    (cluster_boot_addr_o),
        .seq_state_o            (seq_state_o),
        .seq_done_o             (seq_done_o),
        .timeout_err_o          (timeout_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick(input int unsigned n = 1);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // exp = {state, pow, clk_en, rstn, fetch_en, done}
    task automatic chk_ctrl(input string tag, input logic [7:0] exp);
        logic [7:0] obs;
        obs = {seq_state_o, cluster_pow_o, cluster_clk_en_o, cluster_rstn_o,
               cluster_fetch_enable_o, seq_done_o};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_ni            = 1'b0;
        pwr_req_i         = 1'b0;
        boot_addr_i       = '0;
        settle_cycles_i   = '0;
        rst_hold_cycles_i = '0;
        cluster_busy_i    = 1'b0;

        tick(2);
        chk_ctrl("rst_ctrl", {S_OFF, 5'b00000});
        chk_val("rst_boot", cluster_boot_addr_o, 64'h0);
        chk_val("rst_err", {63'h0, timeout_err_o}, 64'h0);

        rst_ni = 1'b1;
        tick(3);
        chk_ctrl("idle_ctrl", {S_OFF, 5'b00000});
        chk_val("idle_boot", cluster_boot_addr_o, 64'h0);

        // Nominal power-up: settle 3, hold 2
        settle_cycles_i   = 8'd3;
        rst_hold_cycles_i = 8'd2;
        boot_addr_i       = 64'h1C00_8080;
        pwr_req_i         = 1'b1;
        tick();
        chk_ctrl("up_c1", {S_PWR_UP, 5'b10000});
        tick(3);
        chk_ctrl("up_c4", {S_PWR_UP, 5'b10000});
        tick();
        chk_ctrl("up_c5", {S_CLK_ON, 5'b11000});
        tick(2);
        chk_ctrl("up_c7", {S_CLK_ON, 5'b11000});
        tick();
        chk_ctrl("up_c8", {S_BOOT, 5'b11100});
        chk_val("up_boot_c8", cluster_boot_addr_o, 64'h1C00_8080);
        boot_addr_i = 64'h0;
        tick();
        chk_ctrl("up_c9", {S_RUN, 5'b11111});
        chk_val("up_boot_c9", cluster_boot_addr_o, 64'h1C00_8080);

        // Drain with busy held for 10 cycles
        cluster_busy_i = 1'b1;
        pwr_req_i      = 1'b0;
        tick();
        chk_ctrl("dn_drain0", {S_DRAIN, 5'b11100});
        tick(9);
        chk_ctrl("dn_drain9", {S_DRAIN, 5'b11100});
        cluster_busy_i = 1'b0;
        tick();
        chk_ctrl("dn_rst_on", {S_RST_ON, 5'b11000});
        tick();
        chk_ctrl("dn_pwr_dn", {S_PWR_DN, 5'b10000});
        tick();
        chk_ctrl("dn_off", {S_OFF, 5'b00001});
        tick();
        chk_ctrl("dn_off2", {S_OFF, 5'b00000});
        chk_val("dn_boot_hold", cluster_boot_addr_o, 64'h1C00_8080);

        // Zero delays; request dropped mid power-up is ignored
        settle_cycles_i   = 8'd0;
        rst_hold_cycles_i = 8'd0;
        boot_addr_i       = 64'hDEAD_BEEF_0000_1234;
        pwr_req_i         = 1'b1;
        tick();
        chk_ctrl("z_pwr_up", {S_PWR_UP, 5'b10000});
        chk_val("z_boot_old", cluster_boot_addr_o, 64'h1C00_8080);
        pwr_req_i = 1'b0;
        tick();
        chk_ctrl("z_clk_on", {S_CLK_ON, 5'b11000});
        tick();
        chk_ctrl("z_boot", {S_BOOT, 5'b11100});
        chk_val("z_boot_new", cluster_boot_addr_o, 64'hDEAD_BEEF_0000_1234);
        tick();
        chk_ctrl("z_run", {S_RUN, 5'b11111});

        // Re-request while draining busy cluster
        cluster_busy_i = 1'b1;
        tick();
        chk_ctrl("rr_drain", {S_DRAIN, 5'b11100});
        tick(2);
        chk_ctrl("rr_drain2", {S_DRAIN, 5'b11100});
        pwr_req_i = 1'b1;
        tick();
        chk_ctrl("rr_run", {S_RUN, 5'b11111});
        tick();
        chk_ctrl("rr_run2", {S_RUN, 5'b11110});

        pwr_req_i      = 1'b0;
        cluster_busy_i = 1'b0;
        tick();
        chk_ctrl("sd_drain", {S_DRAIN, 5'b11100});
        tick();
        chk_ctrl("sd_rst_on", {S_RST_ON, 5'b11000});
        tick();
        chk_ctrl("sd_pwr_dn", {S_PWR_DN, 5'b10000});
        tick();
        chk_ctrl("sd_off", {S_OFF, 5'b00001});

        // Reset during CLK_ON
        settle_cycles_i   = 8'd3;
        rst_hold_cycles_i = 8'd5;
        pwr_req_i         = 1'b1;
        tick(5);
        chk_ctrl("mr_clk_on", {S_CLK_ON, 5'b11000});
        rst_ni    = 1'b0;
        pwr_req_i = 1'b0;
        tick();
        chk_ctrl("mr_off", {S_OFF, 5'b00000});
        chk_val("mr_boot", cluster_boot_addr_o, 64'h0);
        chk_val("mr_err", {63'h0, timeout_err_o}, 64'h0);
        rst_ni = 1'b1;
        tick(2);
        chk_ctrl("mr_idle", {S_OFF, 5'b00000});

        // Stuck-busy drain
        settle_cycles_i   = 8'd0;
        rst_hold_cycles_i = 8'd0;
        pwr_req_i         = 1'b1;
        tick(4);
        chk_ctrl("st_run", {S_RUN, 5'b11111});
        cluster_busy_i = 1'b1;
        pwr_req_i      = 1'b0;
        tick();
        chk_ctrl("st_drain", {S_DRAIN, 5'b11100});
`ifdef CLUSTER_SEQ_TIMEOUT_EN
        tick(14);
        chk_ctrl("to_drain14", {S_DRAIN, 5'b11100});
        chk_val("to_err14", {63'h0, timeout_err_o}, 64'h0);
        tick();
        chk_ctrl("to_rst_on", {S_RST_ON, 5'b11000});
        chk_val("to_err15", {63'h0, timeout_err_o}, 64'h1);
        tick(2);
        chk_ctrl("to_off", {S_OFF, 5'b00001});
        chk_val("to_err_off", {63'h0, timeout_err_o}, 64'h1);
        tick(3);
        chk_val("to_err_sticky", {63'h0, timeout_err_o}, 64'h1);
        rst_ni = 1'b0;
        tick();
        chk_val("to_err_rst", {63'h0, timeout_err_o}, 64'h0);
        rst_ni = 1'b1;
`else
        tick(40);
        chk_ctrl("nt_drain40", {S_DRAIN, 5'b11100});
        chk_val("nt_err", {63'h0, timeout_err_o}, 64'h0);
        cluster_busy_i = 1'b0;
        tick();
        chk_ctrl("nt_rst_on", {S_RST_ON, 5'b11000});
        tick(2);
        chk_ctrl("nt_off", {S_OFF, 5'b00001});
        chk_val("nt_err_off", {63'h0, timeout_err_o}, 64'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
